// File: rtl/dafx_host_sample_reader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dafx_host_sample_reader : decimates the fabric audio stream to the host rate
// and queues whole frames in a FWFT FIFO with a level IRQ.  Rev 1.0
// ----------------------------------------------------------------------------
module dafx_host_sample_reader #(
  parameter int AUDIO_WIDTH_P          = 24,
  parameter int NR_OF_CHANNELS_P       = 3,
  parameter int SAMPLING_IRQ_COUNTER_P = 12500,
  parameter int FIFO_DEPTH_P           = 16
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        x_valid,
  input  logic [NR_OF_CHANNELS_P*AUDIO_WIDTH_P-1:0]   x_frame,
  input  logic                                        cr_enable,
  input  logic                                        cr_clear,
  input  logic [$clog2(FIFO_DEPTH_P):0]               cr_irq_threshold,
  input  logic                                        cr_pop,
  output logic [NR_OF_CHANNELS_P*AUDIO_WIDTH_P-1:0]   sr_frame,
  output logic [$clog2(FIFO_DEPTH_P):0]               sr_fill,
  output logic [15:0]                                 sr_overflow,
  output logic                                        irq
);

  localparam int c_FRAME_W = NR_OF_CHANNELS_P * AUDIO_WIDTH_P;
  localparam int c_PTR_W   = $clog2(FIFO_DEPTH_P);
  localparam int c_FILL_W  = c_PTR_W + 1;
  localparam int c_CNT_W   = (SAMPLING_IRQ_COUNTER_P > 1) ? $clog2(SAMPLING_IRQ_COUNTER_P) : 1;
  localparam logic [c_CNT_W-1:0]  c_CNT_LAST  = c_CNT_W'(SAMPLING_IRQ_COUNTER_P - 1);
  localparam logic [c_FILL_W-1:0] c_FILL_FULL = c_FILL_W'(FIFO_DEPTH_P);
  localparam logic [c_FILL_W-1:0] c_FILL_ONE  = c_FILL_W'(1);

  logic [c_FRAME_W-1:0] r_mem [FIFO_DEPTH_P];
  logic [c_FRAME_W-1:0] r_last_frame;
  logic [c_FRAME_W-1:0] r_frame;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_FILL_W-1:0]  r_fill;
  logic [15:0]          r_overflow;
  logic                 r_irq;

  logic                 w_tick;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_drop;
  logic [c_FRAME_W-1:0] w_push_frame;
  logic [c_PTR_W-1:0]   w_rd_next;
  logic [c_FILL_W-1:0]  w_fill_next;

  assign w_tick       = cr_enable && (r_cnt == c_CNT_LAST);
  assign w_empty      = (r_fill == '0);
  assign w_full       = (r_fill == c_FILL_FULL);
  assign w_pop        = cr_pop && !w_empty && !cr_clear;
  // A full FIFO still takes the push when the host frees a slot in the same cycle.
  assign w_push       = w_tick && (!w_full || w_pop) && !cr_clear;
  assign w_drop       = w_tick && w_full && !w_pop && !cr_clear;
  assign w_push_frame = x_valid ? x_frame : r_last_frame;
  assign w_rd_next    = r_rd_ptr + c_PTR_W'(1);

  always_comb begin
    w_fill_next = r_fill;
    case ({w_push, w_pop})
      2'b10:   w_fill_next = r_fill + c_FILL_ONE;
      2'b01:   w_fill_next = r_fill - c_FILL_ONE;
      default: w_fill_next = r_fill;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_push_frame;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_frame <= '0;
      r_frame      <= '0;
      r_cnt        <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fill       <= '0;
      r_overflow   <= '0;
      r_irq        <= 1'b0;
    end else begin
      if (x_valid) begin
        r_last_frame <= x_frame;
      end
      if (cr_clear) begin
        r_cnt      <= '0;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_fill     <= '0;
        r_overflow <= '0;
        r_irq      <= 1'b0;
      end else begin
        r_cnt  <= (!cr_enable || w_tick) ? '0 : r_cnt + c_CNT_W'(1);
        r_fill <= w_fill_next;
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= w_rd_next;
        end
        if (w_drop && (r_overflow != 16'hFFFF)) begin
          r_overflow <= r_overflow + 16'd1;
        end
        // Head register: the new frame lands here when it becomes the only entry.
        if (w_push && (w_empty || ((r_fill == c_FILL_ONE) && w_pop))) begin
          r_frame <= w_push_frame;
        end else if (w_pop && (r_fill > c_FILL_ONE)) begin
          r_frame <= r_mem[w_rd_next];
        end
        r_irq <= cr_enable && (r_fill >= cr_irq_threshold) && (cr_irq_threshold != '0);
      end
    end
  end

  assign sr_frame    = r_frame;
  assign sr_fill     = r_fill;
  assign sr_overflow = r_overflow;
  assign irq         = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_dafx_host_sample_reader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_dafx_host_sample_reader : directed bench for the host sample reader.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_dafx_host_sample_reader;

  localparam int AW = 24;
  localparam int CH = 3;
  localparam int N  = 10;
  localparam int D  = 4;
  localparam int FW = AW * CH;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          x_valid = 1'b0;
  logic [FW-1:0] x_frame = '0;
  logic          cr_enable = 1'b0;
  logic          cr_clear = 1'b0;
  logic [2:0]    cr_irq_threshold = 3'd0;
  logic          cr_pop = 1'b0;
  logic [FW-1:0] sr_frame;
  logic [2:0]    sr_fill;
  logic [15:0]   sr_overflow;
  logic          irq;

  int n_cmp = 0;
  int n_err = 0;
  int ph = 0;
  logic irq_seen;
  logic [FW-1:0] frm [1:7];

  dafx_host_sample_reader #(
    .AUDIO_WIDTH_P(AW), .NR_OF_CHANNELS_P(CH),
    .SAMPLING_IRQ_COUNTER_P(N), .FIFO_DEPTH_P(D)
  ) u_dut (
    .clk(clk), .rst(rst), .x_valid(x_valid), .x_frame(x_frame),
    .cr_enable(cr_enable), .cr_clear(cr_clear), .cr_irq_threshold(cr_irq_threshold),
    .cr_pop(cr_pop), .sr_frame(sr_frame), .sr_fill(sr_fill),
    .sr_overflow(sr_overflow), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; ph tracks where the period counter should be (9 = tick cycle).
  task automatic step();
    @(negedge clk);
    if (cr_clear || !cr_enable) ph = 0;
    else ph = (ph == N - 1) ? 0 : ph + 1;
  endtask

  task automatic goto_tick();
    for (int i = 0; i < N && ph != N - 1; i++) step();
  endtask

  task automatic restart();
    cr_enable = 1'b0;
    cr_clear  = 1'b1;
    step();
    cr_clear  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 1; k <= 7; k++)
      frm[k] = {AW'(k + 32'h300), AW'(k + 32'h200), AW'(k + 32'h100)};

    // Reset state
    step(); step();
    check_val("rst_frame", sr_frame, '0);
    check_val("rst_fill", FW'(sr_fill), '0);
    check_val("rst_ovf", FW'(sr_overflow), '0);
    check_val("rst_irq", FW'(irq), '0);
    rst = 1'b0;
    step();

    // Basic capture
    cr_enable = 1'b1; cr_irq_threshold = 3'd1;
    x_valid = 1'b1; x_frame = 72'h000003_000002_000001;
    step();
    x_valid = 1'b0;
    goto_tick();
    check_val("basic_pre_tick_fill", FW'(sr_fill), FW'(0));
    step();
    check_val("basic_fill", FW'(sr_fill), FW'(1));
    check_val("basic_frame", sr_frame, 72'h000003_000002_000001);
    check_val("basic_irq_lag", FW'(irq), FW'(0));
    step();
    check_val("basic_irq", FW'(irq), FW'(1));
    cr_pop = 1'b1; step(); cr_pop = 1'b0;
    check_val("basic_pop_fill", FW'(sr_fill), FW'(0));
    step();
    check_val("basic_pop_irq", FW'(irq), FW'(0));

    // Bypass
    restart();
    x_valid = 1'b1; x_frame = 72'h000006_000005_000004; step(); x_valid = 1'b0;
    cr_enable = 1'b1;
    goto_tick();
    x_valid = 1'b1; x_frame = 72'h000006_000005_ABCDEF;
    step();
    x_valid = 1'b0;
    check_val("bypass_frame", sr_frame, 72'h000006_000005_ABCDEF);
    check_val("bypass_fill", FW'(sr_fill), FW'(1));

    // Overflow
    restart();
    cr_enable = 1'b1;
    goto_tick();
    for (int k = 1; k <= 6; k++) begin
      x_valid = 1'b1; x_frame = frm[k];
      step();
      x_valid = 1'b0;
      goto_tick();
    end
    check_val("ovf_fill", FW'(sr_fill), FW'(4));
    check_val("ovf_count", FW'(sr_overflow), FW'(2));
    check_val("ovf_head", sr_frame, frm[1]);
    x_valid = 1'b1; x_frame = frm[7]; cr_pop = 1'b1;
    step();
    x_valid = 1'b0;
    check_val("full_pushpop_fill", FW'(sr_fill), FW'(4));
    check_val("full_pushpop_ovf", FW'(sr_overflow), FW'(2));
    check_val("full_pushpop_head", sr_frame, frm[2]);
    step(); check_val("drain_head3", sr_frame, frm[3]); check_val("drain_fill3", FW'(sr_fill), FW'(3));
    step(); check_val("drain_head4", sr_frame, frm[4]); check_val("drain_fill2", FW'(sr_fill), FW'(2));
    step(); check_val("drain_head7", sr_frame, frm[7]); check_val("drain_fill1", FW'(sr_fill), FW'(1));
    step(); check_val("empty_hold", sr_frame, frm[7]); check_val("empty_fill", FW'(sr_fill), FW'(0));
    step(); cr_pop = 1'b0;
    check_val("pop_empty_fill", FW'(sr_fill), FW'(0));
    check_val("pop_empty_hold", sr_frame, frm[7]);

    // Threshold 3
    restart();
    cr_irq_threshold = 3'd3; cr_enable = 1'b1;
    goto_tick(); step(); step();
    check_val("thr3_irq_1", FW'(irq), FW'(0));
    goto_tick(); step(); step();
    check_val("thr3_irq_2", FW'(irq), FW'(0));
    goto_tick(); step();
    check_val("thr3_fill3", FW'(sr_fill), FW'(3));
    check_val("thr3_irq_lag", FW'(irq), FW'(0));
    step();
    check_val("thr3_irq_3", FW'(irq), FW'(1));
    cr_pop = 1'b1; step(); cr_pop = 1'b0;
    check_val("thr3_pop_fill", FW'(sr_fill), FW'(2));
    step();
    check_val("thr3_pop_irq", FW'(irq), FW'(0));

    // Threshold 0
    cr_irq_threshold = 3'd0;
    irq_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      irq_seen = irq_seen | irq;
    end
    check_val("thr0_irq", FW'(irq_seen), FW'(0));
    check_val("thr0_fill", FW'(sr_fill), FW'(4));
    check_val("thr0_ovf", FW'(sr_overflow), FW'(2));

    // Clear coincident with tick and pop
    cr_pop = 1'b1; step(); step(); cr_pop = 1'b0;
    cr_irq_threshold = 3'd1;
    goto_tick();
    check_val("clr_pre_fill", FW'(sr_fill), FW'(2));
    check_val("clr_pre_irq", FW'(irq), FW'(1));
    cr_clear = 1'b1; cr_pop = 1'b1;
    step();
    cr_clear = 1'b0; cr_pop = 1'b0;
    check_val("clr_fill", FW'(sr_fill), FW'(0));
    check_val("clr_ovf", FW'(sr_overflow), FW'(0));
    check_val("clr_irq", FW'(irq), FW'(0));

    // Disable mid-period
    goto_tick(); step();
    check_val("dis_pre_fill", FW'(sr_fill), FW'(1));
    for (int i = 0; i < N && ph != 5; i++) step();
    cr_enable = 1'b0;
    for (int i = 0; i < 30; i++) step();
    check_val("dis_fill", FW'(sr_fill), FW'(1));
    check_val("dis_irq", FW'(irq), FW'(0));
    cr_pop = 1'b1; step(); cr_pop = 1'b0;
    check_val("dis_pop_fill", FW'(sr_fill), FW'(0));

    // Reset mid-run
    cr_enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      goto_tick(); step();
    end
    check_val("mid_pre_fill", FW'(sr_fill), FW'(3));
    step();
    #2 rst = 1'b1;
    #1;
    check_val("mid_rst_frame", sr_frame, '0);
    check_val("mid_rst_fill", FW'(sr_fill), '0);
    check_val("mid_rst_ovf", FW'(sr_overflow), '0);
    check_val("mid_rst_irq", FW'(irq), '0);
    step(); step();
    rst = 1'b0; ph = 0;
    goto_tick();
    check_val("post_rst_nopush", FW'(sr_fill), FW'(0));
    step();
    check_val("post_rst_push", FW'(sr_fill), FW'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
